// File: rtl/iter_shifter_if.sv
// Handshake and data bundle between the control FSM (master) and iter_shifter (slave).
interface iter_shifter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   dataIn;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, dataIn, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dataIn, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit: shifts by at most STEP bits per cycle until the
// requested amount is consumed, then pulses done for one cycle.
module iter_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input logic         clk,
  input logic         reset,
  iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // One extra bit so STEP = WIDTH is representable.
  localparam logic [SHAMT_W:0] StepW = (SHAMT_W + 1)'(STEP);

  state_e             stateQ, stateD;
  logic [WIDTH-1:0]   resultQ, resultD;
  logic [SHAMT_W-1:0] remainingQ, remainingD;
  logic [1:0]         opQ, opD;

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0] rotDbl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ     <= StIdle;
      resultQ    <= '0;
      remainingQ <= '0;
      opQ        <= 2'b00;
    end else begin
      stateQ     <= stateD;
      resultQ    <= resultD;
      remainingQ <= remainingD;
      opQ        <= opD;
    end
  end

  // Per-step datapath: amt = min(remaining, STEP); amt <= remaining so no underflow.
  always_comb begin
    amt     = ({1'b0, remainingQ} > StepW) ? StepW[SHAMT_W-1:0] : remainingQ;
    rotDbl  = {resultQ, resultQ} >> amt;
    shifted = resultQ;
    unique case (opQ)
      2'b00: shifted = resultQ << amt;
      2'b01: shifted = resultQ >> amt;
      2'b10: shifted = $signed(resultQ) >>> amt;
      2'b11: shifted = rotDbl[WIDTH-1:0];
      default: shifted = resultQ;
    endcase
  end

  always_comb begin
    stateD     = stateQ;
    resultD    = resultQ;
    remainingD = remainingQ;
    opD        = opQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          opD        = bus.op;
          resultD    = bus.dataIn;
          remainingD = bus.shamt;
          stateD     = (bus.shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        resultD    = shifted;
        remainingD = remainingQ - amt;
        if (remainingQ == amt) stateD = StDone;
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.busy   = (stateQ != StIdle);
    bus.done   = (stateQ == StDone);
    bus.result = resultQ;
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed-vector bench for iter_shifter (WIDTH 32, STEP 4) with hand-computed results.
module tb_iter_shifter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request, let the next edge accept it, then scramble the inputs.
  // Returns one step after the accept edge, i.e. in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    bus.op     = op;
    bus.dataIn = data;
    bus.shamt  = sh;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.op     = ~op;
    bus.dataIn = ~data;
    bus.shamt  = ~sh;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] data,
                       input logic [4:0] sh, input logic [31:0] expRes, input int expCyc);
    int cyc;
    issue(op, data, sh);
    waitDone(cyc);
    checkVal({tag, " done cycle"}, cyc, expCyc);
    checkVal({tag, " result"}, bus.result, expRes);
    checkVal({tag, " busy at done"}, {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    checkVal({tag, " idle busy/done"}, {30'b0, bus.busy, bus.done}, 32'd0);
    checkVal({tag, " result held"}, bus.result, expRes);
  endtask

  initial begin
    int cyc;
    int doneSeen;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.dataIn = '0;
    bus.shamt  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset busy/done", {30'b0, bus.busy, bus.done}, 32'd0);
    checkVal("reset result", bus.result, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkVal("post-reset idle", {30'b0, bus.busy, bus.done}, 32'd0);

    // Worst case: SLL 1 by 31, busy in cycles 1..9, done only in 9.
    issue(2'b00, 32'h0000_0001, 5'd31);
    for (int c = 1; c <= 9; c++) begin
      checkVal($sformatf("sll31 busy c%0d", c), {31'b0, bus.busy}, 32'd1);
      checkVal($sformatf("sll31 done c%0d", c), {31'b0, bus.done}, (c == 9) ? 32'd1 : 32'd0);
      if (c < 9) begin
        @(posedge clk);
        #1;
      end
    end
    checkVal("sll31 result", bus.result, 32'h8000_0000);
    @(posedge clk);
    #1;
    checkVal("sll31 idle", {30'b0, bus.busy, bus.done}, 32'd0);

    runOp("sra4",     2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 2);
    runOp("srl4",     2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 2);
    runOp("ror8",     2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 3);
    runOp("sh0 sll",  2'b00, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1);
    runOp("sh0 ror",  2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);
    runOp("sra5 pos", 2'b10, 32'h7FFF_FFF0, 5'd5,  32'h03FF_FFFF, 3);
    runOp("ror1",     2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000, 2);
    runOp("sll13",    2'b00, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_E000, 5);
    runOp("sra31",    2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
    runOp("ror31",    2'b11, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 9);
    runOp("srl16",    2'b01, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD, 5);

    // Starts while busy (cycles 3 and 9) are dropped; cycle 10 start is taken.
    issue(2'b00, 32'h0000_0001, 5'd31);
    for (int c = 1; c <= 10; c++) begin
      if (c == 3 || c == 9) begin
        bus.start  = 1'b1;
        bus.op     = 2'b11;
        bus.dataIn = 32'h0000_FFFF;
        bus.shamt  = 5'd1;
      end else if (c == 10) begin
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.dataIn = 32'h0000_0100;
        bus.shamt  = 5'd4;
        checkVal("ignore result held", bus.result, 32'h8000_0000);
      end else begin
        bus.start = 1'b0;
      end
      checkVal($sformatf("ignore busy c%0d", c), {31'b0, bus.busy}, (c <= 9) ? 32'd1 : 32'd0);
      checkVal($sformatf("ignore done c%0d", c), {31'b0, bus.done}, (c == 9) ? 32'd1 : 32'd0);
      if (c == 9) checkVal("ignore result", bus.result, 32'h8000_0000);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    checkVal("restart accepted", {31'b0, bus.busy}, 32'd1);
    waitDone(cyc);
    checkVal("restart done cycle", cyc, 32'd2);
    checkVal("restart result", bus.result, 32'h0000_0010);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation, between clock edges.
    issue(2'b00, 32'h0000_0001, 5'd31);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkVal("async rst busy/done", {30'b0, bus.busy, bus.done}, 32'd0);
    checkVal("async rst result", bus.result, 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    doneSeen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneSeen++;
    end
    checkVal("no done after rst", doneSeen, 32'd0);
    checkVal("idle after rst", {31'b0, bus.busy}, 32'd0);
    runOp("sll2 after rst", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised shift/rotate unit for the MIPS datapath. It generalises the fixed left-by-2 address shifter to a variable shift amount and four operations: SLL, SRL, SRA and ROR. Each cycle it shifts by up to STEP bits, which trades latency for area. It sits beside the ALU and serves SLL/SRL/SRA/SLLV/SRLV/SRAV, with a start/busy/done handshake to the control FSM.

## Interface
- WIDTH, 32, data width in bits; must be a power of two and ≥ 2.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- STEP, 4, maximum bits shifted per cycle; must be a power of two with 1 ≤ STEP ≤ WIDTH.
- clk  input  1  the single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA (sign fill), 11 ROR (rotate right).
- dataIn  input  WIDTH  operand; captured on the accepted start.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1; captured on the accepted start.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  working/result register.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: performs one shift step per cycle.
  - DONE: asserts done for one cycle.
- Reset (async, any state): state = IDLE, result = 0, remaining = 0, op register = 00, busy = 0, done = 0.
- IDLE with start = 1: latch op, load result ← dataIn and remaining ← shamt.
  - Next state is SHIFT if shamt ≠ 0.
  - Next state is DONE if shamt = 0.
- IDLE with start = 0: all registers hold.
- SHIFT, each cycle:
  - amt = min(remaining, STEP).
  - result is shifted per the latched op by amt.
  - remaining ← remaining − amt.
  - Next state is DONE when remaining − amt = 0; otherwise stay in SHIFT.
- Per-op fill:
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: replicate the current MSB. The sign is preserved across steps because the MSB never changes under SRA.
  - ROR: bits leaving at the LSB re-enter at the MSB.
- DONE: done = 1, then unconditionally go to IDLE.
- result holds its value from DONE until the next accepted start.
- start is ignored in SHIFT and DONE. No queuing; a dropped start must be re-issued once busy = 0.
- dataIn, shamt and op may change freely after the accepting edge without affecting the operation in flight.
- Arithmetic:
  - All shifts are on WIDTH bits; no carry-out.
  - remaining is SHAMT_W bits wide and never underflows, because amt ≤ remaining.
- STEP = WIDTH degenerates to a single SHIFT cycle for any non-zero shamt.

## Timing
- Let n = ceil(shamt / STEP), and let the start-accept edge end cycle 0.
- Cycles 1..n: SHIFT, with busy = 1 and done = 0. result is intermediate and must not be consumed.
- Cycle n+1: DONE, with busy = 1, done = 1 and result final.
- Cycle n+2: IDLE, busy = 0; a new start is accepted in this cycle.
- shamt = 0: done in cycle 1; result = dataIn.
- Worst case (WIDTH = 32, STEP = 4, shamt = 31): n = 8, so done in cycle 9.
- Throughput: one operation per n+2 cycles.
- Reset asserted mid-operation:
  - All outputs go to their reset values without waiting for a clock edge.
  - The operation is lost and done is never asserted for it.
  - After reset deasserts, the first rising edge with start = 1 is accepted.
- done and busy are registered-state decodes, glitch-free relative to clk.

## Test plan
- SLL, dataIn = 0x00000001, shamt = 31, STEP = 4 -> busy in cycles 1–9, done pulse in cycle 9 only, result = 0x80000000.
- SRA, dataIn = 0x80000000, shamt = 4 -> done in cycle 2, result = 0xF8000000. Then SRL with the same operands -> result = 0x08000000.
- ROR, dataIn = 0x12345678, shamt = 8 -> done in cycle 3, result = 0x78123456. Also, shamt = 0 with any op -> done in cycle 1, result = dataIn.
- Issue start with shamt = 31, then pulse start with different operands in cycles 3 and 9 (both while busy) -> both pulses ignored. First result unchanged; the next start is accepted only in cycle 10.
- Assert reset in cycle 4 of an 8-step operation -> busy = 0, done = 0 and result = 0 immediately. No done pulse follows. After release, a fresh SLL 0x3 by 2 -> 0x0000000C.
- Random regression: 10k ops over all op/shamt combinations, for STEP ∈ {1, 4, 32} -> result matches the reference shift model and latency equals ceil(shamt/STEP) + 1.
